// File: rtl/packet_demux.sv
// Channel-tagged Avalon-ST demultiplexer: routes whole packets from one input stream
// to NUM_PORTS registered output streams, dropping and counting unroutable traffic.
module packet_demux #(
   parameter  int NUM_PORTS          = 4,
   parameter  int USER_DATA_WIDTH    = 64,
   parameter  int AVST_ERROR_WIDTH   = 1,
   parameter  int AVST_DATA_WIDTH    = 64,
   parameter  int BIT_POSITION       = 0,
   // get_width(v): number of bits needed to represent the value v
   localparam int AVST_EMPTY_WIDTH   = $clog2(AVST_DATA_WIDTH + 1) - 3,
   localparam int AVST_CHANNEL_WIDTH = (BIT_POSITION != 0) ? NUM_PORTS : $clog2(NUM_PORTS + 1)
) (
   input  logic                          clk,
   input  logic                          rst,
   output logic                          i_avst_ready,
   input  logic                          i_avst_valid,
   input  logic                          i_avst_startofpacket,
   input  logic                          i_avst_endofpacket,
   input  logic [AVST_CHANNEL_WIDTH-1:0] i_avst_channel,
   input  logic [AVST_ERROR_WIDTH-1:0]   i_avst_error,
   input  logic [AVST_EMPTY_WIDTH-1:0]   i_avst_empty,
   input  logic [AVST_DATA_WIDTH-1:0]    i_avst_data,
   input  logic [USER_DATA_WIDTH-1:0]    i_avst_user_data,
   input  logic [NUM_PORTS-1:0]          o_avst_ready,
   output logic [NUM_PORTS-1:0]          o_avst_valid,
   output logic [NUM_PORTS-1:0]          o_avst_startofpacket,
   output logic [NUM_PORTS-1:0]          o_avst_endofpacket,
   output logic [AVST_CHANNEL_WIDTH-1:0] o_avst_channel   [NUM_PORTS],
   output logic [AVST_ERROR_WIDTH-1:0]   o_avst_error     [NUM_PORTS],
   output logic [AVST_EMPTY_WIDTH-1:0]   o_avst_empty     [NUM_PORTS],
   output logic [AVST_DATA_WIDTH-1:0]    o_avst_data      [NUM_PORTS],
   output logic [USER_DATA_WIDTH-1:0]    o_avst_user_data [NUM_PORTS],
   output logic [15:0]                   o_drop_count,
   output logic [1:0]                    dbg_state
);

   localparam int PW = $clog2(NUM_PORTS);

   typedef enum logic [1:0] {
      ST_IDLE = 2'd0,
      ST_FWD  = 2'd1,
      ST_DROP = 2'd2
   } state_t;

   state_t        state;
   logic [PW-1:0] dest;
   logic          chan_ok;
   logic [PW-1:0] chan_port;
   logic          route;
   logic [PW-1:0] tgt;
   logic          accept;
   logic          load;
   logic          drop_evt;

   generate
      if (BIT_POSITION == 0) begin : g_binary
         always_comb begin
            chan_ok   = i_avst_channel < AVST_CHANNEL_WIDTH'(NUM_PORTS);
            chan_port = i_avst_channel[PW-1:0];
         end
      end else begin : g_onehot
         always_comb begin
            chan_ok   = $onehot(i_avst_channel);
            chan_port = '0;
            for (int i = 0; i < NUM_PORTS; i++) begin
               if (i_avst_channel[i]) chan_port = PW'(i);
            end
         end
      end
   endgenerate

   // A SOP always re-decodes the channel, even mid-packet; only FWD continues to dest.
   always_comb begin
      route = 1'b0;
      tgt   = dest;
      if (i_avst_startofpacket) begin
         route = chan_ok;
         tgt   = chan_port;
      end else if (state == ST_FWD) begin
         route = 1'b1;
      end
      if (rst)
         i_avst_ready = 1'b0;
      else if (route)
         i_avst_ready = ~o_avst_valid[tgt] | o_avst_ready[tgt];
      else
         i_avst_ready = 1'b1;
   end

   assign accept   = i_avst_valid & i_avst_ready;
   assign load     = accept & route;
   // Continuation beats of an already-counted dropped packet are not counted again.
   assign drop_evt = accept & ~route & (i_avst_startofpacket | (state != ST_DROP));
   assign dbg_state = state;

   always_ff @(posedge clk) begin
      if (rst) begin
         state        <= ST_IDLE;
         dest         <= '0;
         o_drop_count <= '0;
         o_avst_valid         <= '0;
         o_avst_startofpacket <= '0;
         o_avst_endofpacket   <= '0;
         for (int p = 0; p < NUM_PORTS; p++) begin
            o_avst_channel[p]   <= '0;
            o_avst_error[p]     <= '0;
            o_avst_empty[p]     <= '0;
            o_avst_data[p]      <= '0;
            o_avst_user_data[p] <= '0;
         end
      end else begin
         if (drop_evt && (o_drop_count != 16'hFFFF))
            o_drop_count <= o_drop_count + 16'd1;

         for (int p = 0; p < NUM_PORTS; p++) begin
            if (load && (tgt == PW'(p))) begin
               o_avst_valid[p]         <= 1'b1;
               o_avst_startofpacket[p] <= i_avst_startofpacket;
               o_avst_endofpacket[p]   <= i_avst_endofpacket;
               o_avst_channel[p]       <= i_avst_channel;
               o_avst_error[p]         <= i_avst_error;
               o_avst_empty[p]         <= i_avst_empty;
               o_avst_data[p]          <= i_avst_data;
               o_avst_user_data[p]     <= i_avst_user_data;
            end else if (o_avst_ready[p]) begin
               o_avst_valid[p] <= 1'b0;
            end
         end

         if (accept) begin
            if (i_avst_startofpacket) begin
               if (chan_ok) dest <= chan_port;
               if (i_avst_endofpacket)
                  state <= ST_IDLE;
               else
                  state <= chan_ok ? ST_FWD : ST_DROP;
            end else if (i_avst_endofpacket && (state != ST_IDLE)) begin
               state <= ST_IDLE;
            end
         end
      end
   end

endmodule

// File: tb/tb_packet_demux.sv
// Directed bench for packet_demux: binary-mode instance with a per-port scoreboard,
// plus a one-hot instance for channel decode checks.
module tb_packet_demux;

   localparam int NP  = 4;
   localparam int CW  = 3;
   localparam int OCW = 4;
   localparam int ERW = 1;
   localparam int EW  = 4;
   localparam int DW  = 64;
   localparam int UW  = 64;
   localparam int BW  = 2 + CW + ERW + EW + DW + UW;

   logic           clk = 1'b0;
   logic           rst;
   logic           i_ready;
   logic           i_valid;
   logic           i_sop;
   logic           i_eop;
   logic [CW-1:0]  i_chan;
   logic [ERW-1:0] i_err;
   logic [EW-1:0]  i_empty;
   logic [DW-1:0]  i_data;
   logic [UW-1:0]  i_user;
   logic [NP-1:0]  o_rdy;
   logic [NP-1:0]  o_valid;
   logic [NP-1:0]  o_sop;
   logic [NP-1:0]  o_eop;
   logic [CW-1:0]  o_chan  [NP];
   logic [ERW-1:0] o_err   [NP];
   logic [EW-1:0]  o_empty [NP];
   logic [DW-1:0]  o_data  [NP];
   logic [UW-1:0]  o_user  [NP];
   logic [15:0]    drop_cnt;
   logic [1:0]     dbg_state;

   logic           oh_in_valid;
   logic [OCW-1:0] oh_chan;
   logic           oh_in_ready;
   logic [NP-1:0]  oh_o_rdy;
   logic [NP-1:0]  oh_o_valid;
   logic [NP-1:0]  oh_o_sop;
   logic [NP-1:0]  oh_o_eop;
   logic [OCW-1:0] oh_o_chan  [NP];
   logic [ERW-1:0] oh_o_err   [NP];
   logic [EW-1:0]  oh_o_empty [NP];
   logic [DW-1:0]  oh_o_data  [NP];
   logic [UW-1:0]  oh_o_user  [NP];
   logic [15:0]    oh_drop_cnt;
   logic [1:0]     oh_dbg_state;

   logic [BW-1:0]  exp_q [NP][$];
   logic [BW-1:0]  cur_beat;
   int             n_checks = 0;
   int             n_fail   = 0;

   always #5 clk = ~clk;

   packet_demux #(.NUM_PORTS(NP), .BIT_POSITION(0)) u_dut (
      .clk(clk), .rst(rst), .i_avst_ready(i_ready), .i_avst_valid(i_valid),
      .i_avst_startofpacket(i_sop), .i_avst_endofpacket(i_eop), .i_avst_channel(i_chan),
      .i_avst_error(i_err), .i_avst_empty(i_empty), .i_avst_data(i_data),
      .i_avst_user_data(i_user), .o_avst_ready(o_rdy), .o_avst_valid(o_valid),
      .o_avst_startofpacket(o_sop), .o_avst_endofpacket(o_eop), .o_avst_channel(o_chan),
      .o_avst_error(o_err), .o_avst_empty(o_empty), .o_avst_data(o_data),
      .o_avst_user_data(o_user), .o_drop_count(drop_cnt), .dbg_state(dbg_state)
   );

   packet_demux #(.NUM_PORTS(NP), .BIT_POSITION(1)) u_dut_oh (
      .clk(clk), .rst(rst), .i_avst_ready(oh_in_ready), .i_avst_valid(oh_in_valid),
      .i_avst_startofpacket(i_sop), .i_avst_endofpacket(i_eop), .i_avst_channel(oh_chan),
      .i_avst_error(i_err), .i_avst_empty(i_empty), .i_avst_data(i_data),
      .i_avst_user_data(i_user), .o_avst_ready(oh_o_rdy), .o_avst_valid(oh_o_valid),
      .o_avst_startofpacket(oh_o_sop), .o_avst_endofpacket(oh_o_eop), .o_avst_channel(oh_o_chan),
      .o_avst_error(oh_o_err), .o_avst_empty(oh_o_empty), .o_avst_data(oh_o_data),
      .o_avst_user_data(oh_o_user), .o_drop_count(oh_drop_cnt), .dbg_state(oh_dbg_state)
   );

   task automatic check(input string tag, input logic [BW-1:0] obs, input logic [BW-1:0] exp);
      n_checks++;
      assert (obs === exp) else begin
         n_fail++;
         $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
      end
   endtask

   // Scoreboard: every transfer on an output port must match the oldest expected beat.
   always @(negedge clk) begin
      for (int p = 0; p < NP; p++) begin
         if (!rst && o_valid[p] && o_rdy[p]) begin
            check("port_has_expected", BW'(exp_q[p].size() > 0), BW'(1));
            if (exp_q[p].size() > 0)
               check($sformatf("beat_port%0d", p),
                     {o_sop[p], o_eop[p], o_chan[p], o_err[p], o_empty[p], o_data[p], o_user[p]},
                     exp_q[p].pop_front());
         end
      end
   end

   task automatic set_beat(input logic sop, input logic eop, input logic [CW-1:0] chan);
      i_sop   = sop;
      i_eop   = eop;
      i_chan  = chan;
      i_err   = ERW'($urandom_range(0, 1));
      i_empty = EW'($urandom_range(0, 15));
      i_data  = {$urandom(), $urandom()};
      i_user  = {$urandom(), $urandom()};
      cur_beat = {i_sop, i_eop, i_chan, i_err, i_empty, i_data, i_user};
   endtask

   // Called just after a posedge; expects the beat to be accepted in its first cycle.
   task automatic send_beat(input logic sop, input logic eop, input logic [CW-1:0] chan,
                            input int port);
      int waited = 0;
      set_beat(sop, eop, chan);
      i_valid = 1'b1;
      @(negedge clk);
      while (!i_ready && waited < 50) begin
         waited++;
         @(negedge clk);
      end
      check("accept_no_stall", BW'(waited), BW'(0));
      if (port >= 0) exp_q[port].push_back(cur_beat);
      @(posedge clk);
      #1;
      i_valid = 1'b0;
      if (port >= 0) check("latency_valid", BW'(o_valid[port]), BW'(1));
   endtask

   task automatic check_reset_state(input string tag);
      check({tag, "_valid"}, BW'(o_valid), BW'(0));
      check({tag, "_sop_eop"}, BW'({o_sop, o_eop}), BW'(0));
      check({tag, "_payload"}, {o_chan[2], o_err[2], o_empty[2], o_data[2], o_user[2]}, BW'(0));
      check({tag, "_drop"}, BW'(drop_cnt), BW'(0));
      check({tag, "_state"}, BW'(dbg_state), BW'(0));
   endtask

   initial begin
      #5_000_000;
      $display("FAIL watchdog: simulation did not complete");
      $fatal(1, "watchdog expired");
   end

   initial begin
      rst = 1'b1; i_valid = 1'b1; oh_in_valid = 1'b0; oh_chan = '0;
      o_rdy = '1; oh_o_rdy = '1;
      set_beat(1'b1, 1'b0, 3'd0);
      @(posedge clk); #1;
      check("ready_in_reset", BW'(i_ready), BW'(0));
      @(posedge clk); #1;
      rst = 1'b0; i_valid = 1'b0;
      check_reset_state("reset");

      // Three packets back-to-back with all ports ready
      send_beat(1'b1, 1'b0, 3'd2, 2);
      send_beat(1'b0, 1'b0, 3'd2, 2);
      send_beat(1'b0, 1'b1, 3'd2, 2);
      send_beat(1'b1, 1'b1, 3'd0, 0);
      send_beat(1'b1, 1'b0, 3'd3, 3);
      for (int k = 0; k < 3; k++) send_beat(1'b0, 1'b0, 3'd3, 3);
      send_beat(1'b0, 1'b1, 3'd3, 3);

      // Backpressure on port 1 while it holds a beat
      send_beat(1'b1, 1'b1, 3'd0, 0);
      o_rdy[1] = 1'b0;
      send_beat(1'b1, 1'b0, 3'd1, 1);
      set_beat(1'b0, 1'b0, 3'd1);
      i_valid = 1'b1;
      for (int k = 0; k < 3; k++) begin
         @(negedge clk);
         check("bp_ready_low", BW'(i_ready), BW'(0));
         check("bp_hold_valid", BW'(o_valid[1]), BW'(1));
      end
      @(posedge clk); #1;
      o_rdy[1] = 1'b1;
      @(negedge clk);
      check("bp_ready_release", BW'(i_ready), BW'(1));
      exp_q[1].push_back(cur_beat);
      @(posedge clk); #1;
      i_valid = 1'b0;
      check("bp_new_beat_valid", BW'(o_valid[1]), BW'(1));
      send_beat(1'b0, 1'b1, 3'd1, 1);
      send_beat(1'b1, 1'b1, 3'd0, 0);

      // Invalid channel packet, no port ready: dropped at line rate
      repeat (3) @(posedge clk);
      #1;
      o_rdy = '0;
      send_beat(1'b1, 1'b0, 3'd5, -1);
      check("drop_state", BW'(dbg_state), BW'(2));
      send_beat(1'b0, 1'b0, 3'd5, -1);
      send_beat(1'b0, 1'b0, 3'd2, -1);
      check("drop_count_once", BW'(drop_cnt), BW'(1));
      send_beat(1'b0, 1'b1, 3'd5, -1);
      check("drop_no_output", BW'(o_valid), BW'(0));
      check("drop_count", BW'(drop_cnt), BW'(1));
      check("drop_back_idle", BW'(dbg_state), BW'(0));
      o_rdy = '1;

      // One-hot decode
      set_beat(1'b1, 1'b1, 3'd0);
      oh_chan = 4'b0100; oh_in_valid = 1'b1;
      @(negedge clk);
      check("oh_ready", BW'(oh_in_ready), BW'(1));
      @(posedge clk); #1;
      oh_in_valid = 1'b0;
      check("oh_route_port2", BW'(oh_o_valid), BW'(4'b0100));
      check("oh_data", BW'(oh_o_data[2]), BW'(i_data));
      check("oh_chan_copy", BW'(oh_o_chan[2]), BW'(4'b0100));
      oh_chan = 4'b0110; oh_in_valid = 1'b1;
      @(posedge clk); #1;
      oh_in_valid = 1'b0;
      check("oh_invalid_no_out", BW'(oh_o_valid), BW'(0));
      check("oh_drop_count", BW'(oh_drop_cnt), BW'(1));

      // Orphan beat, then a packet whose channel field changes mid-packet
      rst = 1'b1;
      @(posedge clk); #1;
      rst = 1'b0;
      check_reset_state("reset2");
      send_beat(1'b0, 1'b0, 3'd3, -1);
      check("orphan_drop", BW'(drop_cnt), BW'(1));
      send_beat(1'b1, 1'b0, 3'd1, 1);
      send_beat(1'b0, 1'b0, 3'd0, 1);
      send_beat(1'b0, 1'b1, 3'd0, 1);
      check("orphan_count_after_pkt", BW'(drop_cnt), BW'(1));

      // Drive the drop counter to saturation with orphan beats
      set_beat(1'b0, 1'b0, 3'd0);
      i_valid = 1'b1;
      repeat (65534) @(posedge clk);
      #1;
      check("drop_at_max", BW'(drop_cnt), BW'(16'hFFFF));
      repeat (2) @(posedge clk);
      #1;
      i_valid = 1'b0;
      send_beat(1'b1, 1'b1, 3'd6, -1);
      check("drop_saturated", BW'(drop_cnt), BW'(16'hFFFF));

      // Reset in the middle of a packet with the output stalled
      o_rdy[2] = 1'b0;
      send_beat(1'b1, 1'b0, 3'd2, 2);
      check("mid_pkt_fwd", BW'(dbg_state), BW'(1));
      rst = 1'b1;
      @(posedge clk); #1;
      rst = 1'b0;
      exp_q[2].delete();
      o_rdy = '1;
      check_reset_state("mid_reset");

      repeat (4) @(posedge clk);
      #1;
      for (int p = 0; p < NP; p++)
         check($sformatf("queue_empty_port%0d", p), BW'(exp_q[p].size()), BW'(0));

      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end

endmodule
